// File: rtl/adder_tree_pkg.sv
// Shared constants and state type for the adder tree feeder.
// Both the feeder and its lane buffer use this package.
package adder_tree_pkg;

  localparam int LANES    = 98;
  localparam int WIDTH    = 26;
  localparam int TREE_LAT = 8;
  localparam int LEN_W    = $clog2(LANES + 1);
  localparam int CNT_W    = $clog2(TREE_LAT + 1);
  localparam int OPS_W    = LANES * WIDTH;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/adder_tree_feeder_if.sv
// Sample stream, tree operand/sum, and result handshake bundle for the feeder.
// The master modport is the environment side; the slave modport is the feeder.
interface adder_tree_feeder_if;
  import adder_tree_pkg::*;

  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_last;
  logic             s_ready;
  logic [OPS_W-1:0] tree_ops;
  logic [WIDTH-1:0] tree_sum;
  logic [WIDTH-1:0] res_data;
  logic [LEN_W-1:0] res_len;
  logic             res_valid;
  logic             res_ready;
  logic             busy;

  modport master (
    output s_data, s_valid, s_last, tree_sum, res_ready,
    input  s_ready, tree_ops, res_data, res_len, res_valid, busy
  );

  modport slave (
    input  s_data, s_valid, s_last, tree_sum, res_ready,
    output s_ready, tree_ops, res_data, res_len, res_valid, busy
  );

endinterface

// File: rtl/adder_tree_feeder_lane_buffer.sv
// LANES x WIDTH operand register file: one indexed write per cycle,
// synchronous clear-all, and a flattened read bus feeding the tree directly.
module lane_buffer
  import adder_tree_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [LEN_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  output logic [OPS_W-1:0] rd_flat
);

  logic [LANES-1:0][WIDTH-1:0] lane_q;
  logic [LANES-1:0][WIDTH-1:0] lane_d;

  // Clear wins over write; out-of-range indices leave the lanes untouched.
  always_comb begin
    lane_d = lane_q;
    if (clr) begin
      lane_d = '0;
    end else if (wr_en && (wr_idx < LEN_W'(LANES))) begin
      lane_d[wr_idx] = wr_data;
    end else begin
      lane_d = lane_q;
    end
  end

  // Lane storage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
    end else begin
      lane_q <= lane_d;
    end
  end

  // Packed layout already places lane i at bits [i*WIDTH +: WIDTH].
  assign rd_flat = lane_q;

endmodule

// File: rtl/adder_tree_feeder.sv
// Frame loader and result collector for the adder tree: packs samples into
// operand lanes, waits out the tree latency, then holds the sum for handoff.
module adder_tree_feeder
  import adder_tree_pkg::*;
(
  input  logic                clk,
  input  logic                GlobalReset,
  adder_tree_feeder_if.slave  bus
);

  feeder_state_t    state_q, state_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [LEN_W-1:0] res_len_q, res_len_d;
  logic             res_valid_q, res_valid_d;
  logic             s_ready_q, s_ready_d;
  logic             busy_q, busy_d;
  logic             lane_wr_s;
  logic             lane_clr_s;
  logic             accept_s;

  lane_buffer u_lane_buffer (
    .clk     (clk),
    .rst_n   (GlobalReset),
    .clr     (lane_clr_s),
    .wr_en   (lane_wr_s),
    .wr_idx  (idx_q),
    .wr_data (bus.s_data),
    .rd_flat (bus.tree_ops)
  );

  assign accept_s = bus.s_valid && s_ready_q;

  // Next-state, counters, lane control and result capture.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    res_data_d  = res_data_q;
    res_len_d   = res_len_q;
    res_valid_d = res_valid_q;
    lane_wr_s   = 1'b0;
    lane_clr_s  = 1'b0;

    case (state_q)
      FILL: begin
        if (accept_s) begin
          lane_wr_s = 1'b1;
          idx_d     = idx_q + LEN_W'(1);
          // Frame closes on s_last or once the last lane has been written.
          if (bus.s_last || (idx_q == LEN_W'(LANES - 1))) begin
            state_d   = WAIT;
            cnt_d     = CNT_W'(TREE_LAT);
            res_len_d = idx_q + LEN_W'(1);
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end

      WAIT: begin
        if (cnt_q == CNT_W'(0)) begin
          res_data_d  = bus.tree_sum;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      HOLD: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          lane_clr_s  = 1'b1;
          idx_d       = LEN_W'(0);
          state_d     = FILL;
        end else begin
          state_d = HOLD;
        end
      end

      default: begin
        state_d     = FILL;
        idx_d       = LEN_W'(0);
        cnt_d       = CNT_W'(0);
        res_valid_d = 1'b0;
        lane_clr_s  = 1'b1;
      end
    endcase

    // Registered decode of the next state keeps s_ready free of input paths.
    s_ready_d = (state_d == FILL);
    busy_d    = (state_d != FILL);
  end

  // State, counter and result registers.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      state_q     <= FILL;
      idx_q       <= LEN_W'(0);
      cnt_q       <= CNT_W'(0);
      res_data_q  <= WIDTH'(0);
      res_len_q   <= LEN_W'(0);
      res_valid_q <= 1'b0;
      s_ready_q   <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      res_data_q  <= res_data_d;
      res_len_q   <= res_len_d;
      res_valid_q <= res_valid_d;
      s_ready_q   <= s_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_len   = res_len_q;
  assign bus.res_valid = res_valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_adder_tree_feeder.sv
// Directed bench for adder_tree_feeder with a behavioural TREE_LAT-deep
// adder tree model driving tree_sum from the operand bus.
module tb_adder_tree_feeder;
  import adder_tree_pkg::*;

  logic clk = 1'b0;
  logic GlobalReset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  adder_tree_feeder_if bus ();

  adder_tree_feeder dut (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .bus         (bus)
  );

  // Tree model: sum of all lanes, modulo 2^WIDTH, delayed TREE_LAT edges.
  logic [WIDTH-1:0] ops_sum;
  logic [WIDTH-1:0] pipe [TREE_LAT];

  always_comb begin
    ops_sum = '0;
    for (int i = 0; i < LANES; i++) ops_sum = ops_sum + bus.tree_ops[i*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk) begin
    pipe[0] <= ops_sum;
    for (int k = 1; k < TREE_LAT; k++) pipe[k] <= pipe[k-1];
  end

  assign bus.tree_sum = pipe[TREE_LAT-1];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one sample and hold it until an edge where s_ready was high.
  task automatic send(input logic [WIDTH-1:0] d, input logic last);
    logic rdy;
    int   n;
    bus.s_data  = d;
    bus.s_last  = last;
    bus.s_valid = 1'b1;
    n = 0;
    do begin
      rdy = bus.s_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 200);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    if (!rdy) check_eq("send_timeout", 32'(rdy), 32'd1);
  endtask

  // Called #1 after the closing accept edge; expects res_valid 9 edges later.
  task automatic wait_result(input string tag, input int exp_data, input int exp_len);
    int n;
    n = 0;
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'd1);
    check_eq({tag, "_sready_wait"}, 32'(bus.s_ready), 32'd0);
    while (!bus.res_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, "_latency"}, 32'(n), 32'd9);
    check_eq({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
    check_eq({tag, "_data"}, 32'(bus.res_data), 32'(exp_data));
    check_eq({tag, "_len"}, 32'(bus.res_len), 32'(exp_len));
  endtask

  task automatic handoff(input string tag);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check_eq({tag, "_valid_clr"}, 32'(bus.res_valid), 32'd0);
    check_eq({tag, "_sready_back"}, 32'(bus.s_ready), 32'd1);
    check_eq({tag, "_busy_clr"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_ops_clr"}, 32'(|bus.tree_ops), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    GlobalReset   = 1'b0;
    bus.s_data    = '0;
    bus.s_valid   = 1'b0;
    bus.s_last    = 1'b0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_sready", 32'(bus.s_ready), 32'd1);
    check_eq("rst_valid", 32'(bus.res_valid), 32'd0);
    check_eq("rst_data", 32'(bus.res_data), 32'd0);
    check_eq("rst_len", 32'(bus.res_len), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_ops", 32'(|bus.tree_ops), 32'd0);
    GlobalReset = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // 1..98 closed by s_last on the 98th sample.
    for (int i = 1; i <= 98; i++) send(WIDTH'(i), (i == 98));
    wait_result("ramp", 4851, 98);
    handoff("ramp");

    // Single sample; res_ready held high early must not shorten WAIT.
    send(WIDTH'(5), 1'b1);
    bus.res_ready = 1'b1;
    wait_result("single", 5, 1);
    handoff("single");

    // Full frame of ones, then a short frame proving the lanes were cleared.
    for (int i = 1; i <= 98; i++) send(WIDTH'(1), (i == 98));
    wait_result("ones", 98, 98);
    handoff("ones");
    send(WIDTH'(10), 1'b0);
    send(WIDTH'(20), 1'b0);
    send(WIDTH'(30), 1'b1);
    wait_result("short", 60, 3);
    handoff("short");

    // Auto-close after 98 samples; the 99th waits, unconsumed, through WAIT/HOLD.
    for (int i = 1; i <= 98; i++) send(WIDTH'(1), 1'b0);
    bus.s_data  = WIDTH'(1);
    bus.s_last  = 1'b0;
    bus.s_valid = 1'b1;
    wait_result("auto", 98, 98);
    handoff("auto");
    send(WIDTH'(1), 1'b0);
    send(WIDTH'(1), 1'b1);
    wait_result("auto2", 2, 2);
    handoff("auto2");

    // Modulo wrap passes through unchanged.
    send(26'h3FF_FFFF, 1'b0);
    send(WIDTH'(2), 1'b1);
    wait_result("wrap", 1, 2);
    handoff("wrap");

    // Backpressure: result held for 20 cycles with res_ready low.
    send(WIDTH'(100), 1'b0);
    send(WIDTH'(200), 1'b1);
    wait_result("hold", 300, 2);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", 32'(bus.res_valid), 32'd1);
      check_eq("hold_data", 32'(bus.res_data), 32'd300);
      check_eq("hold_sready", 32'(bus.s_ready), 32'd0);
    end
    handoff("hold");

    // Asynchronous reset mid-WAIT discards the frame immediately.
    send(WIDTH'(9), 1'b1);
    repeat (3) @(posedge clk);
    #2;
    GlobalReset = 1'b0;
    #1;
    check_eq("arst_valid", 32'(bus.res_valid), 32'd0);
    check_eq("arst_ops", 32'(|bus.tree_ops), 32'd0);
    check_eq("arst_busy", 32'(bus.busy), 32'd0);
    #2;
    GlobalReset = 1'b1;
    @(posedge clk); #1;
    check_eq("arst_sready", 32'(bus.s_ready), 32'd1);
    send(WIDTH'(7), 1'b1);
    wait_result("post_rst", 7, 1);
    handoff("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adder_tree_feeder.md
# adder_tree_feeder

Frame loader and result collector for the 98-lane fixed-point adder tree. It accepts a stream of 26-bit fixed-point samples over a valid/ready handshake and packs up to LANES samples into a registered operand bus that drives the tree's base-level adders. It then waits out the tree's pipeline latency and captures the final sum into a held result register with its own valid/ready handshake. It is the producer and consumer end of the tree: the tree's base adders read `tree_ops`, and the final adder drives `tree_sum`.

## Interface
- `LANES`, 98: operand lanes presented to the tree.
- `WIDTH`, 26: fixed-point sample/sum width.
- `TREE_LAT`, 8: clock edges from an operand-register update to the matching value on `tree_sum` (base level plus 7 reduction levels, 1 cycle each).
- `clk` in 1: single clock, rising edge.
- `GlobalReset` in 1: asynchronous, active-low reset.
- `s_data` in WIDTH: input sample.
- `s_valid` in 1: sample valid.
- `s_last` in 1: sample closes the frame.
- `s_ready` out 1: feeder accepts a sample this cycle.
- `tree_ops` out LANES*WIDTH: registered operands; lane i occupies bits [i*WIDTH +: WIDTH].
- `tree_sum` in WIDTH: final adder output.
- `res_data` out WIDTH: captured frame sum.
- `res_len` out 7: samples in the captured frame (1..LANES).
- `res_valid` out 1: result held.
- `res_ready` in 1: downstream takes the result.
- `busy` out 1: high in any state other than FILL.

## Operation
- States: FILL, WAIT, HOLD.
- **FILL**
  - `s_ready`=1.
  - Each accepted sample (`s_valid` && `s_ready`) writes `lane[idx]` and increments `idx`.
  - Go to WAIT on the accepting edge if `s_last`=1 or `idx`==LANES-1.
  - At that edge, load `cnt`=TREE_LAT and latch `res_len`=`idx`+1.
- **WAIT**
  - `s_ready`=0; the lanes are frozen.
  - `cnt` decrements every edge.
  - When `cnt`==0, capture `res_data`<=`tree_sum`, set `res_valid`=1, and go to HOLD.
- **HOLD**
  - `res_valid`=1; `res_data` and `res_len` are stable.
  - On the edge with `res_ready`=1: clear `res_valid`, clear all lanes to zero, set `idx`=0, and go to FILL.
- Zero padding: lanes not written in a frame are zero, because the lanes are cleared at every handoff and at reset.
- Auto-close: after LANES samples without `s_last`, the frame closes. The next sample belongs to the next frame.
- `s_valid` while `s_ready`=0 is ignored, and the sample is not consumed.
- Arithmetic: the feeder does no arithmetic. `res_data` is `tree_sum` verbatim, so modulo-2^WIDTH wrap in the tree passes through unchanged.
- Reset values: `s_ready`=1, `tree_ops`=0, `res_data`=0, `res_len`=0, `res_valid`=0, `busy`=0, state FILL, `idx`=0, `cnt`=0.
- Reset mid-frame or mid-WAIT: the partial frame and any pending result are discarded. Reset is asynchronous and has no drain.

## Timing
- Closing sample accepted at edge e0:
  - `tree_ops` is final after e0.
  - `tree_sum` is valid after e0+TREE_LAT.
  - `res_valid` rises after edge e0+TREE_LAT+1, i.e. 9 edges with the defaults.
- `res_ready` high when `res_valid` rises gives the handoff on the next edge. `s_ready` returns 1 in the cycle after the handoff edge.
- `res_ready` is ignored outside HOLD.
- Minimum frame period: `res_len` + TREE_LAT + 2 cycles.
- `s_ready` is a registered state decode. There is no combinational path from `res_ready` to `s_ready` or from `s_valid` to `s_ready`.

## Structure
- Shared package `adder_tree_pkg` holds:
  - LANES, WIDTH, TREE_LAT;
  - the state enum `feeder_state_t` {FILL, WAIT, HOLD};
  - the `res_len` width localparam, $clog2(LANES+1).
- One sub-module is natural: `lane_buffer`, the LANES×WIDTH register file with indexed write, synchronous clear-all, and a flattened read bus. FSM, counters and result capture stay in the top level.

## Test plan
- Stream 1..98 with `s_last` on 98 -> `res_data`=4851, `res_len`=98, `res_valid` 9 edges after the last accept.
- Single sample 5 with `s_last` -> `res_data`=5, `res_len`=1 (lanes 1..97 zero).
- Full frame of 1s (98 samples, then `s_last` on the 98th), then frame 10,20,30 with `s_last` -> second `res_data`=60, `res_len`=3; proves the lane clear.
- 100 samples of 1, no `s_last`, then `s_last` on sample 100:
  - first frame -> `res_data`=98, `res_len`=98 (auto-close);
  - second frame -> `res_data`=2, `res_len`=2.
- Hold `res_ready`=0 for 20 cycles after `res_valid` -> `res_valid`=1, `res_data` stable, `s_ready`=0 throughout; handoff on the first `res_ready` edge.
- Assert `GlobalReset`=0 mid-WAIT -> `res_valid`=0 and `tree_ops`=0 immediately; after release `s_ready`=1; next frame 7 with `s_last` -> `res_data`=7.
